sync_frame_fifo: RTL and testbench

- Single-clock, store-and-forward frame FIFO; successor to the dual-clock byte frame FIFO on the Ethernet TX path.
- Parametrised data width, depth and committed-frame limit.
- A frame becomes readable only after its EOF beat is accepted.
- Adds frame abort/rewind, oversize/overflow frame drop, selectable back-pressure mode, and frame/level/drop status. Sits between packet builders (UDP/ARP) and the MAC TX path.

---
 rtl/sync_frame_fifo.sv | 170 +++++++++++++++++
 tb/tb_sync_frame_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_frame_fifo.sv
// Single-clock store-and-forward frame FIFO: a frame becomes visible to the reader only
// once its EOF beat is written. Aborted, restarted and oversize frames are rewound away.
module sync_frame_fifo #(
    parameter int P_DATA_W       = 8,
    parameter int P_DEPTH        = 4096,
    parameter int P_MAX_FRAMES   = 16,
    parameter int P_DROP_ON_FULL = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_sof,
    input  logic                              wr_eof,
    input  logic [P_DATA_W-1:0]               wr_data,
    input  logic                              wr_vld,
    output logic                              wr_rdy,
    input  logic                              wr_abort,
    output logic                              rd_sof,
    output logic                              rd_eof,
    output logic [P_DATA_W-1:0]               rd_data,
    output logic                              rd_vld,
    input  logic                              rd_rdy,
    output logic [$clog2(P_MAX_FRAMES+1)-1:0] frm_cnt,
    output logic [$clog2(P_DEPTH):0]          level,
    output logic                              drop_pulse,
    output logic [15:0]                       drop_cnt,
    output logic [1:0]                        wr_state_probe
);
    localparam int AW = $clog2(P_DEPTH);
    localparam int PW = AW + 1;
    localparam int FW = $clog2(P_MAX_FRAMES + 1);
    localparam int MW = P_DATA_W + 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_DISCARD = 2'd2
    } wr_state_t;

    wr_state_t     state, state_nxt;
    logic [PW-1:0] wr_ptr, wr_ptr_nxt, cmt_ptr, cmt_ptr_nxt, rd_ptr, fetch_ptr, used;
    logic          rdy_en, full, frames_full, can_drop, wr_fire, commit, drop_evt;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [MW-1:0] mem_wdata;
    logic [MW-1:0] mem [P_DEPTH];
    logic [MW-1:0] ram_q, out_q;
    logic          ram_vld, out_vld, out_load, rd_issue, rd_pop;

    // Occupancy never exceeds P_DEPTH, so its MSB alone flags full.
    assign used        = wr_ptr - rd_ptr;
    assign full        = used[PW-1];
    assign frames_full = (frm_cnt == FW'(P_MAX_FRAMES));
    assign can_drop    = (P_DROP_ON_FULL != 0) || (cmt_ptr == rd_ptr);

    always_comb begin
        state_nxt   = state;
        wr_ptr_nxt  = wr_ptr;
        cmt_ptr_nxt = cmt_ptr;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr[AW-1:0];
        mem_wdata   = {wr_sof, wr_eof, wr_data};
        commit      = 1'b0;
        drop_evt    = 1'b0;
        case (state)
            S_IDLE:    wr_rdy = rdy_en && !frames_full && !full;
            S_WRITE:   wr_rdy = rdy_en && (!full || can_drop);
            S_DISCARD: wr_rdy = rdy_en;
            default:   wr_rdy = 1'b0;
        endcase
        wr_fire = wr_vld && wr_rdy;

        if (wr_abort) begin
            wr_ptr_nxt = cmt_ptr;
            state_nxt  = S_IDLE;
        end else if (wr_fire) begin
            case (state)
                S_IDLE, S_WRITE: begin
                    // A new frame always starts at cmt_ptr, which also discards any partial frame.
                    if (wr_sof) begin
                        drop_evt   = (state == S_WRITE);
                        mem_we     = 1'b1;
                        mem_waddr  = cmt_ptr[AW-1:0];
                        wr_ptr_nxt = cmt_ptr + 1'b1;
                        if (wr_eof) begin
                            cmt_ptr_nxt = cmt_ptr + 1'b1;
                            commit      = 1'b1;
                            state_nxt   = S_IDLE;
                        end else begin
                            state_nxt   = S_WRITE;
                        end
                    end else if (state == S_WRITE) begin
                        if (full) begin
                            drop_evt   = 1'b1;
                            wr_ptr_nxt = cmt_ptr;
                            state_nxt  = wr_eof ? S_IDLE : S_DISCARD;
                        end else begin
                            mem_we     = 1'b1;
                            wr_ptr_nxt = wr_ptr + 1'b1;
                            if (wr_eof) begin
                                cmt_ptr_nxt = wr_ptr + 1'b1;
                                commit      = 1'b1;
                                state_nxt   = S_IDLE;
                            end
                        end
                    end
                end
                S_DISCARD: if (wr_eof) state_nxt = S_IDLE;
                default: ;
            endcase
        end
    end

    // fetch_ptr runs up to two beats ahead of rd_ptr to fill the RAM and output stages;
    // rd_ptr only moves on a pop so prefetched slots stay protected.
    assign rd_pop   = out_vld && rd_rdy;
    assign out_load = ram_vld && (!out_vld || rd_rdy);
    assign rd_issue = (fetch_ptr != cmt_ptr) && (!ram_vld || out_load);

    always_ff @(posedge clk) begin
        if (mem_we)   mem[mem_waddr] <= mem_wdata;
        if (rd_issue) ram_q <= mem[fetch_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en     <= 1'b0;
            state      <= S_IDLE;
            wr_ptr     <= '0;
            cmt_ptr    <= '0;
            rd_ptr     <= '0;
            fetch_ptr  <= '0;
            ram_vld    <= 1'b0;
            out_vld    <= 1'b0;
            out_q      <= '0;
            frm_cnt    <= '0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            rdy_en  <= 1'b1;
            state   <= state_nxt;
            wr_ptr  <= wr_ptr_nxt;
            cmt_ptr <= cmt_ptr_nxt;
            if (rd_pop)   rd_ptr    <= rd_ptr + 1'b1;
            if (rd_issue) fetch_ptr <= fetch_ptr + 1'b1;
            if (rd_issue)      ram_vld <= 1'b1;
            else if (out_load) ram_vld <= 1'b0;
            if (out_load) begin
                out_q   <= ram_q;
                out_vld <= 1'b1;
            end else if (rd_pop) begin
                out_vld <= 1'b0;
            end
            case ({commit, rd_pop && out_q[MW-2]})
                2'b10:   frm_cnt <= frm_cnt + 1'b1;
                2'b01:   frm_cnt <= frm_cnt - 1'b1;
                default: ;
            endcase
            drop_pulse <= drop_evt;
            if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign rd_vld         = out_vld;
    assign rd_sof         = out_q[MW-1];
    assign rd_eof         = out_q[MW-2];
    assign rd_data        = out_q[P_DATA_W-1:0];
    assign level          = used;
    assign wr_state_probe = state;

endmodule

// File: tb/tb_sync_frame_fifo.sv
// Scoreboard bench for sync_frame_fifo (16-beat store, 4-frame limit, back-pressure mode):
// the writer queues every beat expected to come out, a monitor pops on each read transfer.
module tb_sync_frame_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int MAXF  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_sof, wr_eof, wr_vld, wr_rdy, wr_abort;
    logic [DW-1:0] wr_data;
    logic          rd_sof, rd_eof, rd_vld, rd_rdy;
    logic [DW-1:0] rd_data;
    logic [2:0]    frm_cnt;
    logic [4:0]    level;
    logic          drop_pulse;
    logic [15:0]   drop_cnt;
    logic [1:0]    wr_state_probe;

    int         checks    = 0;
    int         failures  = 0;
    int         drop_seen = 0;
    int         max_frm   = 0;
    int         beats_acc = 0;
    bit         wdone     = 1'b0;
    logic [9:0] exp_q[$];

    sync_frame_fifo #(
        .P_DATA_W(DW), .P_DEPTH(DEPTH), .P_MAX_FRAMES(MAXF), .P_DROP_ON_FULL(0)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_sof(wr_sof), .wr_eof(wr_eof), .wr_data(wr_data), .wr_vld(wr_vld),
        .wr_rdy(wr_rdy), .wr_abort(wr_abort),
        .rd_sof(rd_sof), .rd_eof(rd_eof), .rd_data(rd_data), .rd_vld(rd_vld), .rd_rdy(rd_rdy),
        .frm_cnt(frm_cnt), .level(level), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt),
        .wr_state_probe(wr_state_probe)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One beat: held until wr_rdy is seen at a negedge, so it transfers on the next posedge.
    task automatic writeBeat(input logic sof, input logic eof, input logic [DW-1:0] data, input bit keep);
        bit done = 1'b0;
        wr_vld = 1'b1; wr_sof = sof; wr_eof = eof; wr_data = data;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (wr_rdy) begin
                done = 1'b1;
                beats_acc++;
                if (keep) exp_q.push_back({sof, eof, data});
            end
            @(posedge clk); #1;
        end
        wr_vld = 1'b0; wr_sof = 1'b0; wr_eof = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("[TB] FAIL write_timeout: got no wr_rdy expected accept within 400 cycles");
        end
    endtask

    task automatic applyStimulus(input int len, input logic [DW-1:0] base, input bit keep,
                                 input bit send_eof, input int gap_max, output int drop_at);
        drop_at = 0;
        for (int i = 1; i <= len; i++) begin
            writeBeat(i == 1, send_eof && (i == len), base + DW'(i - 1), keep);
            if (drop_pulse && drop_at == 0) drop_at = i;
            if (gap_max > 0) repeat (int'($urandom_range(gap_max))) begin @(posedge clk); #1; end
        end
    endtask

    task automatic waitDrain();
        int t = 0;
        while ((exp_q.size() != 0 || frm_cnt != 0 || rd_vld) && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        checkOutput("drain_queue_left", 32'(exp_q.size()), 0);
        checkOutput("drain_level", 32'(level), 0);
    endtask

    // Monitor: compares every read transfer against the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (int'(frm_cnt) > max_frm) max_frm = int'(frm_cnt);
                if (drop_pulse) drop_seen++;
                if (rd_vld && rd_rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("[TB] FAIL rd_unexpected: got %0h expected none", {rd_sof, rd_eof, rd_data});
                    end else begin
                        checkOutput("rd_beat", 32'({rd_sof, rd_eof, rd_data}), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        int drop_at, drop_at2, cyc, t;
        wr_sof = 0; wr_eof = 0; wr_vld = 0; wr_abort = 0; wr_data = '0; rd_rdy = 0;

        repeat (3) @(posedge clk); #1;
        checkOutput("rst_wr_rdy", 32'(wr_rdy), 0);
        checkOutput("rst_rd_vld", 32'(rd_vld), 0);
        checkOutput("rst_frm_cnt", 32'(frm_cnt), 0);
        checkOutput("rst_level", 32'(level), 0);
        checkOutput("rst_drop", 32'({drop_pulse, drop_cnt}), 0);
        rst = 0;
        @(posedge clk); #1;
        checkOutput("wr_rdy_after_rst", 32'(wr_rdy), 1);

        $display("[TB] frames 5/1/8, latency and full-rate drain");
        max_frm = 0;
        applyStimulus(5, 8'h10, 1, 1, 0, drop_at);
        @(posedge clk); #1;
        checkOutput("lat_eof_plus1", 32'(rd_vld), 0);
        @(posedge clk); #1;
        checkOutput("lat_eof_plus2", 32'(rd_vld), 1);
        applyStimulus(1, 8'hA0, 1, 1, 0, drop_at);
        applyStimulus(8, 8'h40, 1, 1, 0, drop_at);
        checkOutput("t1_frm_cnt", 32'(frm_cnt), 3);
        checkOutput("t1_level", 32'(level), 14);
        rd_rdy = 1; cyc = 0;
        while (frm_cnt != 0 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        checkOutput("t1_drain_cycles", 32'(cyc), 14);
        checkOutput("t1_frm_peak", 32'(max_frm), 3);
        waitDrain();

        $display("[TB] oversize frame drop");
        rd_rdy = 0; drop_seen = 0;
        applyStimulus(20, 8'h80, 0, 1, 0, drop_at);
        checkOutput("drop_at_beat", 32'(drop_at), 17);
        checkOutput("drop_cnt_1", 32'(drop_cnt), 1);
        checkOutput("drop_level", 32'(level), 0);
        checkOutput("drop_probe_idle", 32'(wr_state_probe), 0);
        applyStimulus(4, 8'hC0, 1, 1, 0, drop_at);
        rd_rdy = 1;
        waitDrain();
        checkOutput("drop_pulses", 32'(drop_seen), 1);

        $display("[TB] abort after 6 beats");
        rd_rdy = 0;
        applyStimulus(6, 8'h20, 0, 0, 0, drop_at);
        checkOutput("abort_probe_write", 32'(wr_state_probe), 1);
        wr_abort = 1; @(posedge clk); #1; wr_abort = 0;
        checkOutput("abort_level", 32'(level), 0);
        checkOutput("abort_probe_idle", 32'(wr_state_probe), 0);
        applyStimulus(3, 8'h30, 1, 1, 0, drop_at);
        rd_rdy = 1;
        waitDrain();
        checkOutput("abort_drop_cnt", 32'(drop_cnt), 1);

        $display("[TB] back-pressure on full");
        rd_rdy = 0;
        applyStimulus(10, 8'h50, 1, 1, 0, drop_at);
        beats_acc = 0;
        fork
            applyStimulus(8, 8'h60, 1, 1, 0, drop_at2);
            begin
                t = 0;
                while (beats_acc < 6 && t < 200) begin @(posedge clk); #1; t++; end
                repeat (4) begin @(posedge clk); #1; end
                checkOutput("bp_beats", 32'(beats_acc), 6);
                checkOutput("bp_wr_rdy", 32'(wr_rdy), 0);
                checkOutput("bp_level", 32'(level), 16);
                rd_rdy = 1;
            end
        join
        waitDrain();

        $display("[TB] 1000 frames, random gaps and rd_rdy");
        max_frm = 0; wdone = 0;
        fork
            begin
                for (int f = 0; f < 1000; f++)
                    applyStimulus(int'($urandom_range(12, 1)), DW'($urandom), 1, 1, 2, drop_at);
                wdone = 1;
            end
            begin
                while (!wdone) begin
                    rd_rdy = ($urandom_range(3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        rd_rdy = 1;
        waitDrain();
        checkOutput("rand_frm_within_max", 32'(max_frm <= MAXF), 1);
        checkOutput("rand_drop_cnt", 32'(drop_cnt), 1);

        $display("[TB] reset mid-read");
        rd_rdy = 0;
        applyStimulus(3, 8'h70, 1, 1, 0, drop_at);
        applyStimulus(4, 8'h78, 1, 1, 0, drop_at);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("pre_rst_rd_vld", 32'(rd_vld), 1);
        checkOutput("pre_rst_frm_cnt", 32'(frm_cnt), 2);
        #2 rst = 1;
        #1;
        checkOutput("mid_rst_rd", 32'({rd_vld, rd_sof, rd_eof, rd_data}), 0);
        checkOutput("mid_rst_wr_rdy", 32'(wr_rdy), 0);
        checkOutput("mid_rst_counts", 32'({frm_cnt, level, drop_pulse}), 0);
        checkOutput("mid_rst_drop_cnt", 32'(drop_cnt), 0);
        exp_q.delete();
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;
        checkOutput("post_rst_wr_rdy", 32'(wr_rdy), 1);
        checkOutput("post_rst_level", 32'(level), 0);
        checkOutput("post_rst_frm_cnt", 32'(frm_cnt), 0);
        applyStimulus(2, 8'hE0, 1, 1, 0, drop_at);
        rd_rdy = 1;
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
